// File: rtl/ntt_butterfly_unit_if.sv
// Operand/result bundle between the coefficient-memory read stage,
// the NTT butterfly and the write-back stage.
interface ntt_butterfly_unit_if;
  logic        clken;
  logic        in_valid;
  logic        mode;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] w;
  logic        out_valid;
  logic [15:0] x;
  logic [15:0] y;

  // Read stage side: supplies operands, observes results
  modport master (
    output clken, in_valid, mode, a, b, w,
    input  out_valid, x, y
  );

  // Butterfly side: consumes operands, produces results
  modport slave (
    input  clken, in_valid, mode, a, b, w,
    output out_valid, x, y
  );
endinterface

// File: rtl/ntt_butterfly_unit.sv
// Radix-2 NTT/INTT butterfly over Z_q (q = 12289), 4 registered stages.
// mode 0 = Cooley-Tukey (forward), mode 1 = Gentleman-Sande (inverse).
// Every register is gated by bus.clken so the pipeline freezes as a unit.
module ntt_butterfly_unit #(
  parameter int unsigned Q         = 12289,
  parameter int unsigned BARRETT_M = 21843,
  parameter int unsigned BARRETT_K = 28
) (
  input  logic               clk,
  input  logic               rst,
  ntt_butterfly_unit_if.slave bus
);

  localparam int unsigned DW = 16;  // coefficient width
  localparam int unsigned SW = 17;  // sum/diff width
  localparam int unsigned PW = 28;  // product width
  localparam int unsigned BW = 44;  // Barrett product width

  localparam logic [DW-1:0] Q_D = DW'(Q);
  localparam logic [SW-1:0] Q_S = SW'(Q);
  localparam logic [PW-1:0] Q_P = PW'(Q);
  localparam logic [BW-1:0] M_B = BW'(BARRETT_M);

  // ---------------- E1 front end: GS pre-add/sub ----------------
  logic [SW-1:0] sum_raw;
  logic [SW-1:0] sum_red;
  logic [SW-1:0] dif_raw;
  logic [SW-1:0] dif_red;

  assign sum_raw = SW'(bus.a) + SW'(bus.b);
  assign sum_red = (sum_raw >= Q_S) ? (sum_raw - Q_S) : sum_raw;
  assign dif_raw = SW'(bus.a) + Q_S - SW'(bus.b);
  assign dif_red = (dif_raw >= Q_S) ? (dif_raw - Q_S) : dif_raw;

  // E1 registers
  logic          v1;
  logic          mode1;
  logic [DW-1:0] mul_op1;
  logic [DW-1:0] pass1;
  logic [DW-1:0] w1;

  // E2 registers
  logic          v2;
  logic          mode2;
  logic [PW-1:0] t2;
  logic [DW-1:0] pass2;

  // E3 registers
  logic          v3;
  logic          mode3;
  logic [DW-1:0] r3;
  logic [DW-1:0] pass3;

  // E1: capture operands, pick multiplier operand and pass-through by mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1      <= 1'b0;
      mode1   <= 1'b0;
      mul_op1 <= '0;
      pass1   <= '0;
      w1      <= '0;
    end else if (bus.clken) begin
      v1      <= bus.in_valid;
      mode1   <= bus.mode;
      mul_op1 <= bus.mode ? DW'(dif_red) : bus.b;
      pass1   <= bus.mode ? DW'(sum_red) : bus.a;
      w1      <= bus.w;
    end
  end

  // E2: full-width modular product operand t = mul_op * w
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      mode2 <= 1'b0;
      t2    <= '0;
      pass2 <= '0;
    end else if (bus.clken) begin
      v2    <= v1;
      mode2 <= mode1;
      t2    <= PW'(mul_op1) * PW'(w1);
      pass2 <= pass1;
    end
  end

  // ---------------- E3 Barrett reduction datapath ----------------
  logic [BW-1:0] bprod;
  logic [DW-1:0] qh;
  logic [PW-1:0] r_raw;
  logic [SW-1:0] r_a;
  logic [SW-1:0] r_b;
  logic [SW-1:0] r_c;

  assign bprod = BW'(t2) * M_B;
  assign qh    = DW'(bprod >> BARRETT_K);
  assign r_raw = t2 - (PW'(qh) * Q_P);
  // r_raw lies in [0, 3Q) for in-range operands, so 17 bits suffice
  assign r_a   = SW'(r_raw);
  assign r_b   = (r_a >= Q_S) ? (r_a - Q_S) : r_a;
  assign r_c   = (r_b >= Q_S) ? (r_b - Q_S) : r_b;

  // E3: register the fully reduced product and the delayed pass operand
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3    <= 1'b0;
      mode3 <= 1'b0;
      r3    <= '0;
      pass3 <= '0;
    end else if (bus.clken) begin
      v3    <= v2;
      mode3 <= mode2;
      r3    <= DW'(r_c);
      pass3 <= pass2;
    end
  end

  // ---------------- E4 CT post-add/sub ----------------
  logic [SW-1:0] x_sum;
  logic [SW-1:0] x_red;
  logic [SW-1:0] y_dif;
  logic [DW-1:0] x_next;
  logic [DW-1:0] y_next;

  assign x_sum  = SW'(pass3) + SW'(r3);
  assign x_red  = (x_sum >= Q_S) ? (x_sum - Q_S) : x_sum;
  assign y_dif  = (pass3 >= r3) ? (SW'(pass3) - SW'(r3))
                                : (SW'(pass3) + Q_S - SW'(r3));
  assign x_next = mode3 ? pass3 : DW'(x_red);
  assign y_next = mode3 ? r3    : DW'(y_dif);

  // E4: output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.x         <= '0;
      bus.y         <= '0;
    end else if (bus.clken) begin
      bus.out_valid <= v3;
      bus.x         <= x_next;
      bus.y         <= y_next;
    end
  end

  // Q_D documents the coefficient range; keep it referenced for clarity
  logic unused_q;
  assign unused_q = ^Q_D;

endmodule
